// File: rtl/ber_pkg.sv
// Shared types and constants for the BER run sequencer.
package ber_pkg;

    localparam int BER_CW = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_WARMUP,
        ST_RUN,
        ST_DONE
    } ber_state_t;

    localparam logic [1:0] STOP_NONE  = 2'd0;
    localparam logic [1:0] STOP_BITS  = 2'd1;
    localparam logic [1:0] STOP_ERRS  = 2'd2;
    localparam logic [1:0] STOP_STALL = 2'd3;

endpackage

// File: rtl/ber_test_ctrl_if.sv
// Software-facing control/status bundle of the BER run sequencer.
interface ber_test_ctrl_if
    import ber_pkg::*;
#(
    parameter int CW = BER_CW
);
    logic          start;
    logic          abort;
    logic          cfg_precode;
    logic [CW-1:0] cfg_target_bits;
    logic [CW-1:0] cfg_target_errors;
    logic          busy;
    logic          done;
    logic [CW-1:0] result_bits;
    logic [CW-1:0] result_errors;
    logic [1:0]    stop_reason;

    modport master (
        output start, abort, cfg_precode, cfg_target_bits, cfg_target_errors,
        input  busy, done, result_bits, result_errors, stop_reason
    );

    modport slave (
        input  start, abort, cfg_precode, cfg_target_bits, cfg_target_errors,
        output busy, done, result_bits, result_errors, stop_reason
    );

endinterface

// File: rtl/ber_stall_mon.sv
// Flags a stall once the checker bit count has stayed unchanged for
// STALL_CYCLES consecutive cycles; clr_i restarts tracking from the current value.
module ber_stall_mon
    import ber_pkg::*;
#(
    parameter int CW           = BER_CW,
    parameter int STALL_CYCLES = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic [CW-1:0] bits_i,
    output logic          stall_o
);
    localparam int            IW        = $clog2(STALL_CYCLES + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(STALL_CYCLES - 1);

    logic [CW-1:0] prev_q, prev_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          same;

    // idle_q counts earlier unchanged cycles; the current one completes the streak
    always_comb begin
        same    = (bits_i == prev_q);
        prev_d  = bits_i;
        idle_d  = idle_q;
        if (clr_i || !same) begin
            idle_d = '0;
        end else if (idle_q != IDLE_LAST) begin
            idle_d = idle_q + IW'(1);
        end
        stall_o = !clr_i && same && (idle_q == IDLE_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= '0;
            idle_q <= '0;
        end else begin
            prev_q <= prev_d;
            idle_q <= idle_d;
        end
    end

endmodule

// File: rtl/ber_test_ctrl.sv
// BER run sequencer: flushes and warms up the chain, baselines the checker
// counters, then runs to a target or stall and latches the measured result.
module ber_test_ctrl
    import ber_pkg::*;
#(
    parameter int FLUSH_CYCLES  = 16,
    parameter int WARMUP_CYCLES = 64,
    parameter int STALL_CYCLES  = 1024,
    parameter int CW            = BER_CW
) (
    input  logic           clk,
    input  logic           rst,
    ber_test_ctrl_if.slave sw,
    input  logic [CW-1:0]  total_bits_i,
    input  logic [CW-1:0]  total_bit_errors_i,
    output logic           chain_rstn_o,
    output logic           chain_en_o,
    output logic           precode_mode_o
);
    ber_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] tgt_bits_q, tgt_bits_d, tgt_errs_q, tgt_errs_d;
    logic [CW-1:0] base_bits_q, base_bits_d, base_errs_q, base_errs_d;
    logic [CW-1:0] res_bits_q, res_bits_d, res_errs_q, res_errs_d;
    logic [1:0]    reason_q, reason_d;
    logic          chain_rstn_q, chain_rstn_d, chain_en_q, chain_en_d;
    logic          precode_q, precode_d, busy_q, busy_d, done_q, done_d;
    logic          stall_clr, stall;
    logic [CW-1:0] meas_bits, meas_errs;
    logic          hit_errs, hit_bits;

    ber_stall_mon #(
        .CW           (CW),
        .STALL_CYCLES (STALL_CYCLES)
    ) u_stall_mon (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (stall_clr),
        .bits_i  (total_bits_i),
        .stall_o (stall)
    );

    // Modulo-2^CW deltas keep the measurement correct across checker counter wrap
    assign meas_bits = total_bits_i - base_bits_q;
    assign meas_errs = total_bit_errors_i - base_errs_q;
    assign hit_errs  = (tgt_errs_q != '0) && (meas_errs >= tgt_errs_q);
    assign hit_bits  = (tgt_bits_q != '0) && (meas_bits >= tgt_bits_q);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tgt_bits_d   = tgt_bits_q;
        tgt_errs_d   = tgt_errs_q;
        base_bits_d  = base_bits_q;
        base_errs_d  = base_errs_q;
        res_bits_d   = res_bits_q;
        res_errs_d   = res_errs_q;
        reason_d     = reason_q;
        chain_rstn_d = chain_rstn_q;
        chain_en_d   = chain_en_q;
        precode_d    = precode_q;
        done_d       = 1'b0;
        stall_clr    = 1'b0;

        if (sw.abort) begin
            state_d      = ST_IDLE;
            chain_en_d   = 1'b0;
            chain_rstn_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (sw.start) begin
                        state_d      = ST_FLUSH;
                        cnt_d        = '0;
                        tgt_bits_d   = sw.cfg_target_bits;
                        tgt_errs_d   = sw.cfg_target_errors;
                        precode_d    = sw.cfg_precode;
                        chain_rstn_d = 1'b0;
                        chain_en_d   = 1'b0;
                    end
                end
                ST_FLUSH: begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(FLUSH_CYCLES - 1)) begin
                        state_d      = ST_WARMUP;
                        cnt_d        = '0;
                        chain_rstn_d = 1'b1;
                        chain_en_d   = 1'b1;
                    end
                end
                ST_WARMUP: begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WARMUP_CYCLES - 1)) begin
                        state_d     = ST_RUN;
                        cnt_d       = '0;
                        base_bits_d = total_bits_i;
                        base_errs_d = total_bit_errors_i;
                        stall_clr   = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (hit_errs || hit_bits || stall) begin
                        state_d    = ST_DONE;
                        done_d     = 1'b1;
                        chain_en_d = 1'b0;
                        res_bits_d = meas_bits;
                        res_errs_d = meas_errs;
                        reason_d   = hit_errs ? STOP_ERRS : (hit_bits ? STOP_BITS : STOP_STALL);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d == ST_FLUSH) || (state_d == ST_WARMUP) || (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            tgt_bits_q   <= '0;
            tgt_errs_q   <= '0;
            base_bits_q  <= '0;
            base_errs_q  <= '0;
            res_bits_q   <= '0;
            res_errs_q   <= '0;
            reason_q     <= STOP_NONE;
            chain_rstn_q <= 1'b0;
            chain_en_q   <= 1'b0;
            precode_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tgt_bits_q   <= tgt_bits_d;
            tgt_errs_q   <= tgt_errs_d;
            base_bits_q  <= base_bits_d;
            base_errs_q  <= base_errs_d;
            res_bits_q   <= res_bits_d;
            res_errs_q   <= res_errs_d;
            reason_q     <= reason_d;
            chain_rstn_q <= chain_rstn_d;
            chain_en_q   <= chain_en_d;
            precode_q    <= precode_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign chain_rstn_o     = chain_rstn_q;
    assign chain_en_o       = chain_en_q;
    assign precode_mode_o   = precode_q;
    assign sw.busy          = busy_q;
    assign sw.done          = done_q;
    assign sw.result_bits   = res_bits_q;
    assign sw.result_errors = res_errs_q;
    assign sw.stop_reason   = reason_q;

endmodule

// File: tb/tb_ber_test_ctrl.sv
// Scoreboard bench for ber_test_ctrl: per-run checker traces are scanned with the
// stop rules to predict the done cycle and results; a monitor checks each done pulse.
module tb_ber_test_ctrl;
    import ber_pkg::*;

    localparam int CW     = 32;
    localparam int FL     = 16;
    localparam int WU     = 64;
    localparam int ST     = 1024;
    localparam int BASE_N = FL + WU;   // start-relative edge at which the baseline is sampled

    typedef struct {
        int            at_edge;
        logic [CW-1:0] bits;
        logic [CW-1:0] errs;
        logic [1:0]    reason;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CW-1:0] total_bits = '0;
    logic [CW-1:0] total_errs = '0;
    logic          chain_rstn, chain_en, precode_mode;
    int            edge_cnt = 0;
    int            total = 0;
    int            bad = 0;
    exp_t          sb_q[$];
    logic [CW-1:0] seq_b[];
    logic [CW-1:0] seq_e[];
    logic [CW-1:0] last_bits = '0;
    logic [CW-1:0] last_errs = '0;
    logic [1:0]    last_reason = STOP_NONE;

    ber_test_ctrl_if #(.CW(CW)) sw ();

    ber_test_ctrl #(
        .FLUSH_CYCLES  (FL),
        .WARMUP_CYCLES (WU),
        .STALL_CYCLES  (ST),
        .CW            (CW)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .sw                 (sw),
        .total_bits_i       (total_bits),
        .total_bit_errors_i (total_errs),
        .chain_rstn_o       (chain_rstn),
        .chain_en_o         (chain_en),
        .precode_mode_o     (precode_mode)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_chain_rstn"}, 64'(chain_rstn), 64'(0));
        check({tag, "_chain_en"}, 64'(chain_en), 64'(0));
        check({tag, "_precode"}, 64'(precode_mode), 64'(0));
        check({tag, "_busy"}, 64'(sw.busy), 64'(0));
        check({tag, "_done"}, 64'(sw.done), 64'(0));
        check({tag, "_result_bits"}, 64'(sw.result_bits), 64'(0));
        check({tag, "_result_errors"}, 64'(sw.result_errors), 64'(0));
        check({tag, "_stop_reason"}, 64'(sw.stop_reason), 64'(STOP_NONE));
    endtask

    // Monitor: every done pulse must match the oldest predicted run outcome
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && sw.done) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 at edge %0d, want no done", edge_cnt);
            end else begin
                e = sb_q.pop_front();
                check("done_edge", 64'(edge_cnt), 64'(e.at_edge));
                check("result_bits", 64'(sw.result_bits), 64'(e.bits));
                check("result_errors", 64'(sw.result_errors), 64'(e.errs));
                check("stop_reason", 64'(sw.stop_reason), 64'(e.reason));
                check("chain_en_at_done", 64'(chain_en), 64'(0));
                check("busy_at_done", 64'(sw.busy), 64'(0));
            end
        end
    end

    task automatic gen_ramp(input int run_len, input logic [CW-1:0] base_val);
        seq_b = new[BASE_N + run_len + 1];
        seq_e = new[BASE_N + run_len + 1];
        for (int n = 0; n < seq_b.size(); n++) begin
            seq_b[n] = base_val + CW'(n) - CW'(BASE_N);
            seq_e[n] = '0;
        end
    endtask

    task automatic gen_random();
        logic [CW-1:0] b, e;
        int            act_len;
        act_len = 500;
        seq_b   = new[BASE_N + act_len + ST + 8];
        seq_e   = new[BASE_N + act_len + ST + 8];
        b       = $urandom;
        e       = $urandom;
        for (int n = 0; n < seq_b.size(); n++) begin
            if (n > 0 && n <= BASE_N + act_len) begin
                b = b + CW'($urandom_range(0, 3));
                if ($urandom_range(0, 15) == 0) e = e + CW'(1);
            end
            seq_b[n] = b;
            seq_e[n] = e;
        end
    endtask

    // Scan the trace: first RUN cycle k meeting error target, bit target or stall
    task automatic compute_expect(input logic [CW-1:0] tb_bits, input logic [CW-1:0] tb_errs,
                                  output int kstop, output logic [1:0] r,
                                  output logic [CW-1:0] mb, output logic [CW-1:0] me);
        logic [CW-1:0] db, de;
        int            streak;
        kstop  = -1;
        r      = STOP_NONE;
        mb     = '0;
        me     = '0;
        streak = 0;
        for (int k = 1; BASE_N + k < seq_b.size(); k++) begin
            db     = seq_b[BASE_N + k] - seq_b[BASE_N];
            de     = seq_e[BASE_N + k] - seq_e[BASE_N];
            streak = (seq_b[BASE_N + k] == seq_b[BASE_N + k - 1]) ? streak + 1 : 0;
            if (tb_errs != 0 && de >= tb_errs) r = STOP_ERRS;
            else if (tb_bits != 0 && db >= tb_bits) r = STOP_BITS;
            else if (streak >= ST) r = STOP_STALL;
            if (r != STOP_NONE) begin
                kstop = k;
                mb    = db;
                me    = de;
                break;
            end
        end
    endtask

    task automatic run_seq(input logic pre, input logic [CW-1:0] tb_bits, input logic [CW-1:0] tb_errs,
                           input int pulse_at, input int rst_at);
        int            kstop, e0, last_n;
        logic [1:0]    r;
        logic [CW-1:0] mb, me;
        exp_t          e;
        compute_expect(tb_bits, tb_errs, kstop, r, mb, me);
        if (kstop < 0 && rst_at < 0) begin
            total++;
            bad++;
            $display("FAIL stimulus_no_stop: got no stop point, want one");
            return;
        end
        sw.cfg_precode       = pre;
        sw.cfg_target_bits   = tb_bits;
        sw.cfg_target_errors = tb_errs;
        e0 = edge_cnt + 1;
        if (rst_at < 0) begin
            e.at_edge = e0 + BASE_N + kstop;
            e.bits    = mb;
            e.errs    = me;
            e.reason  = r;
            sb_q.push_back(e);
            last_bits   = mb;
            last_errs   = me;
            last_reason = r;
            last_n      = BASE_N + kstop + 2;
        end else begin
            last_n = rst_at;
        end
        for (int n = 0; n <= last_n; n++) begin
            total_bits = seq_b[(n < seq_b.size()) ? n : seq_b.size() - 1];
            total_errs = seq_e[(n < seq_e.size()) ? n : seq_e.size() - 1];
            sw.start   = (n == 0) || (n == pulse_at);
            rst        = (n == rst_at);
            @(posedge clk);
            #1;
            if (n == 0) begin
                check("flush_chain_rstn", 64'(chain_rstn), 64'(0));
                check("flush_busy", 64'(sw.busy), 64'(1));
                check("flush_precode", 64'(precode_mode), 64'(pre));
            end
            if (n == FL - 1) check("flush_chain_en_low", 64'(chain_en), 64'(0));
            if (n == FL) begin
                check("release_chain_en", 64'(chain_en), 64'(1));
                check("release_chain_rstn", 64'(chain_rstn), 64'(1));
            end
            if (n == BASE_N + 1) check("run_busy", 64'(sw.busy), 64'(1));
            if (n == rst_at) check_reset_outputs("midrun_rst");
        end
        sw.start = 1'b0;
        rst      = 1'b0;
        if (rst_at < 0) begin
            check("after_done_busy", 64'(sw.busy), 64'(0));
            check("after_done_chain_en", 64'(chain_en), 64'(0));
            check("after_done_chain_rstn", 64'(chain_rstn), 64'(1));
            check("after_done_reason", 64'(sw.stop_reason), 64'(r));
        end
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: got no end of test, want finish before timeout");
        $fatal(1, "timeout");
    end

    initial begin : driver
        int ecnt;
        sw.start             = 1'b0;
        sw.abort             = 1'b0;
        sw.cfg_precode       = 1'b0;
        sw.cfg_target_bits   = '0;
        sw.cfg_target_errors = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Bit target, checker counting 1 bit/cycle from 0 at chain release; start pulsed in WARMUP
        gen_ramp(1100, 32'd63);
        for (int n = 0; n <= FL; n++) seq_b[n] = '0;
        run_seq(1'b0, 32'd1000, 32'd0, 30, -1);

        // Error target wins: 3rd error lands on bit 500; start pulsed in RUN
        gen_ramp(600, 32'd0);
        for (int n = 0; n < seq_e.size(); n++) begin
            ecnt = 0;
            if (n >= BASE_N + 100) ecnt++;
            if (n >= BASE_N + 300) ecnt++;
            if (n >= BASE_N + 500) ecnt++;
            seq_e[n] = CW'(ecnt);
        end
        run_seq(1'b1, 32'd500, 32'd3, BASE_N + 100, -1);

        // Counter wrap across the baseline
        gen_ramp(600, 32'hFFFF_FF00);
        run_seq(1'b0, 32'd512, 32'd0, -1, -1);

        // Stall: total_bits freezes 200 cycles into RUN, no targets
        gen_ramp(1300, 32'd1000);
        for (int n = BASE_N + 201; n < seq_b.size(); n++) seq_b[n] = seq_b[BASE_N + 200];
        run_seq(1'b1, 32'd0, 32'd0, -1, -1);

        // Abort in WARMUP: back to IDLE, results of the previous run kept
        gen_ramp(200, 32'h10);
        total_bits     = seq_b[0];
        sw.cfg_precode = 1'b0;
        sw.start       = 1'b1;
        @(posedge clk);
        #1;
        sw.start = 1'b0;
        repeat (39) @(posedge clk);
        #1;
        check("abort_pre_busy", 64'(sw.busy), 64'(1));
        sw.abort = 1'b1;
        sw.start = 1'b1;
        @(posedge clk);
        #1;
        sw.abort = 1'b0;
        sw.start = 1'b0;
        check("abort_busy", 64'(sw.busy), 64'(0));
        check("abort_chain_rstn", 64'(chain_rstn), 64'(0));
        check("abort_chain_en", 64'(chain_en), 64'(0));
        check("abort_kept_bits", 64'(sw.result_bits), 64'(last_bits));
        check("abort_kept_errors", 64'(sw.result_errors), 64'(last_errs));
        check("abort_kept_reason", 64'(sw.stop_reason), 64'(last_reason));
        sw.abort = 1'b1;
        sw.start = 1'b1;
        @(posedge clk);
        #1;
        sw.abort = 1'b0;
        sw.start = 1'b0;
        check("abort_beats_start", 64'(sw.busy), 64'(0));

        // Next run re-flushes with precode 1
        gen_random();
        run_seq(1'b1, CW'($urandom_range(50, 900)), CW'($urandom_range(1, 40)), -1, -1);

        // Randomized runs
        for (int i = 0; i < 8; i++) begin
            logic [CW-1:0] tbv, tev;
            tbv = ($urandom_range(0, 3) == 0) ? '0 : CW'($urandom_range(50, 900));
            tev = ($urandom_range(0, 3) == 0) ? '0 : CW'($urandom_range(1, 40));
            gen_random();
            run_seq(1'($urandom_range(0, 1)), tbv, tev, $urandom_range(1, BASE_N + 50), -1);
        end

        // Reset mid-RUN after an ignored start in RUN
        gen_ramp(400, 32'd5);
        run_seq(1'b1, 32'd0, 32'd0, BASE_N + 20, BASE_N + 60);
        repeat (5) @(posedge clk);
        #1;
        check("post_reset_idle_busy", 64'(sw.busy), 64'(0));
        check("scoreboard_drained", 64'(sb_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
